// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC encoder/checker pair: state encoding,
// default polynomial parameters and the single-bit LFSR step.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Widest LFSR the step function supports; callers pass their real width.
    localparam int          CRC_MAX_W     = 64;
    localparam int          CRC_WIDTH_DEF = 16;
    localparam logic [15:0] CRC_POLY_DEF  = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEF  = 16'h0000;

    // MSB-first Galois step: fb = msb ^ bit, shift left, xor in poly on fb.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] lfsr,
        input logic                 d,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   width = CRC_WIDTH_DEF
    );
        logic [CRC_MAX_W-1:0] msb_vec;
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] shifted;
        logic                 fb;
        msb_vec = lfsr >> (width - 1);
        fb      = msb_vec[0] ^ d;
        mask    = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - width);
        shifted = (lfsr << 1) & mask;
        return fb ? (shifted ^ (poly & mask)) : shifted;
    endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC remainder register. i_clr reseeds from INIT; with i_en in the same
// cycle the incoming bit is folded into the fresh seed rather than the old state.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int             W    = CRC_WIDTH_DEF,
    parameter logic [W-1:0]   POLY = W'(CRC_POLY_DEF),
    parameter logic [W-1:0]   INIT = W'(CRC_INIT_DEF)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_rem
);

    logic [W-1:0] rem_reg;
    logic [W-1:0] rem_next;
    logic [W-1:0] rem_base;

    always_comb begin
        rem_base = i_clr ? INIT : rem_reg;
        rem_next = rem_base;
        if (i_en) begin
            rem_next = W'(crc_step(CRC_MAX_W'(rem_base), i_bit, CRC_MAX_W'(POLY), W));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_reg <= INIT;
        end else begin
            rem_reg <= rem_next;
        end
    end

    assign o_rem = rem_reg;

endmodule

// File: rtl/crc_check.sv
// Serial CRC checker: passes DATA_LEN payload bits through, then consumes
// CRC_WIDTH check bits and reports pass/fail once per completed frame.
module crc_check
    import crc_pkg::*;
#(
    parameter int                   DATA_LEN  = 16,
    parameter int                   CRC_WIDTH = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC_POLY_DEF),
    parameter logic [CRC_WIDTH-1:0] INIT      = CRC_WIDTH'(CRC_INIT_DEF)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sof,
    input  logic i_valid,
    input  logic i_data,
    output logic o_data,
    output logic o_data_valid,
    output logic o_busy,
    output logic o_crc_done,
    output logic o_crc_err
);

    localparam int MAX_LEN = (DATA_LEN > CRC_WIDTH) ? DATA_LEN : CRC_WIDTH;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_WIDTH - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   data_reg, data_next;
    logic                   data_valid_reg, data_valid_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;
    logic                   lfsr_clr;
    logic                   lfsr_en;
    logic                   start;
    logic [CRC_WIDTH-1:0]   rem;
    logic [CRC_WIDTH-1:0]   rem_after;

    crc_lfsr #(
        .W    (CRC_WIDTH),
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (lfsr_clr),
        .i_en  (lfsr_en),
        .i_bit (i_data),
        .o_rem (rem)
    );

    assign start     = i_sof & i_valid;
    // Remainder once the current bit is folded in; zero after the last CRC bit means a good frame.
    assign rem_after = CRC_WIDTH'(crc_step(CRC_MAX_W'(rem), i_data, CRC_MAX_W'(POLY), CRC_WIDTH));

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        data_next       = data_reg;
        data_valid_next = 1'b0;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        err_next        = err_reg;
        lfsr_clr        = 1'b0;
        lfsr_en         = 1'b0;

        if (start) begin
            // A start always wins, aborting any frame in flight without a done pulse.
            lfsr_clr        = 1'b1;
            lfsr_en         = 1'b1;
            data_next       = i_data;
            data_valid_next = 1'b1;
            busy_next       = 1'b1;
            if (DATA_LEN == 1) begin
                state_next = ST_CHECK;
                cnt_next   = '0;
            end else begin
                state_next = ST_DATA;
                cnt_next   = CNT_W'(1);
            end
        end else if (i_valid) begin
            case (state_reg)
                ST_DATA: begin
                    lfsr_en         = 1'b1;
                    data_next       = i_data;
                    data_valid_next = 1'b1;
                    if (cnt_reg == LAST_DATA) begin
                        state_next = ST_CHECK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    lfsr_en = 1'b1;
                    if (cnt_reg == LAST_CRC) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        err_next   = (rem_after != '0);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            data_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    assign o_data       = data_reg;
    assign o_data_valid = data_valid_reg;
    // An accepted start counts as busy already, so back-to-back frames show no idle gap.
    assign o_busy       = (busy_reg | start) & ~i_rst;
    assign o_crc_done   = done_reg;
    assign o_crc_err    = err_reg;

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check: instance 0 uses DATA_LEN=16, instance 1 DATA_LEN=72.
// Expected CRCs come from polynomial long division over the frame bits.
module tb_crc_check;

    localparam int          W      = 16;
    localparam logic [15:0] POLY_C = 16'h1021;

    typedef struct {
        bit v;
        int cyc;
    } exp_t;
    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sof = '0;
    logic [1:0] valid = '0;
    logic [1:0] din = '0;
    logic [1:0] dout, dvalid, busy, done, err;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int exp_done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_check #(.DATA_LEN(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_sof(sof[0]), .i_valid(valid[0]), .i_data(din[0]),
        .o_data(dout[0]), .o_data_valid(dvalid[0]), .o_busy(busy[0]),
        .o_crc_done(done[0]), .o_crc_err(err[0])
    );

    crc_check #(.DATA_LEN(72)) dut72 (
        .i_clk(clk), .i_rst(rst), .i_sof(sof[1]), .i_valid(valid[1]), .i_data(din[1]),
        .o_data(dout[1]), .o_data_valid(dvalid[1]), .o_busy(busy[1]),
        .o_crc_done(done[1]), .o_crc_err(err[1])
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop and compare whenever an instance presents data or a frame result.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mon
            exp_t qd[$];
            exp_t qe[$];
            int   n_done = 0;
            int   n_dv   = 0;
            always @(negedge clk) begin
                exp_t e;
                if (!rst) begin
                    if (dvalid[gi]) begin
                        n_dv++;
                        check("data_expected", int'(qd.size() > 0), 1);
                        if (qd.size() > 0) begin
                            e = qd.pop_front();
                            check("data_bit", int'(dout[gi]), int'(e.v));
                            check("data_cycle", cyc, e.cyc);
                        end
                    end
                    if (done[gi]) begin
                        n_done++;
                        check("done_expected", int'(qe.size() > 0), 1);
                        if (qe.size() > 0) begin
                            e = qe.pop_front();
                            check("crc_err", int'(err[gi]), int'(e.v));
                            check("done_cycle", cyc, e.cyc);
                        end
                        $display("inst %0d frame %0d done: err=%0b cycle=%0d", gi, n_done, err[gi], cyc);
                    end
                end
            end
        end
    endgenerate

    function automatic bitq_t bits_of(input logic [71:0] v, input int n);
        bitq_t q;
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
        return q;
    endfunction

    function automatic bitq_t rand_bits(input int n);
        bitq_t q;
        for (int i = 0; i < n; i++) q.push_back(1'($urandom));
        return q;
    endfunction

    // Remainder of payload * x^16 divided by the generator, by mod-2 long division.
    function automatic logic [15:0] crc_ref(input bitq_t pay);
        bit          a[$];
        bit          g[17];
        logic [15:0] p;
        logic [15:0] r;
        p = POLY_C;
        a = pay;
        for (int j = 0; j < W; j++) a.push_back(1'b0);
        g[0] = 1'b1;
        for (int j = 0; j < W; j++) g[j + 1] = p[W - 1 - j];
        for (int i = 0; i < pay.size(); i++) begin
            if (a[i]) begin
                for (int j = 0; j <= W; j++) a[i + j] = a[i + j] ^ g[j];
            end
        end
        for (int j = 0; j < W; j++) r[W - 1 - j] = a[pay.size() + j];
        return r;
    endfunction

    task automatic push_d(input int s, input exp_t e);
        if (s == 0) g_mon[0].qd.push_back(e);
        else        g_mon[1].qd.push_back(e);
    endtask

    task automatic push_e(input int s, input exp_t e);
        if (s == 0) g_mon[0].qe.push_back(e);
        else        g_mon[1].qe.push_back(e);
    endtask

    task automatic idle_cycle(input int s);
        @(posedge clk);
        #1;
        valid[s] = 1'b0;
        sof[s]   = 1'($urandom);
        din[s]   = 1'($urandom);
    endtask

    task automatic idle(input int s, input int n);
        repeat (n) idle_cycle(s);
    endtask

    // Sends the first stop_at bits of payload+crc; a truncated frame expects no result.
    task automatic send_frame(input int s, input bitq_t pay, input logic [15:0] crc,
                              input int gap_pct, input int stop_at, input bit chk_busy);
        bitq_t fr;
        bit    exp_err;
        exp_t  e;
        fr = pay;
        for (int i = W - 1; i >= 0; i--) fr.push_back(crc[i]);
        exp_err = (crc != crc_ref(pay));
        for (int i = 0; i < stop_at; i++) begin
            int g = 0;
            while (g < 6 && $urandom_range(99) < gap_pct) begin
                idle_cycle(s);
                g++;
            end
            @(posedge clk);
            #1;
            sof[s]   = (i == 0);
            valid[s] = 1'b1;
            din[s]   = fr[i];
            if (i < pay.size()) begin
                e.v = fr[i]; e.cyc = cyc + 1;
                push_d(s, e);
            end
            if (i == fr.size() - 1) begin
                e.v = exp_err; e.cyc = cyc + 1;
                push_e(s, e);
                exp_done_cnt[s]++;
            end
            if (chk_busy) begin
                @(negedge clk);
                check("busy_b2b", int'(busy[s]), 1);
            end
        end
    endtask

    task automatic check_all_zero(input int s, input string tag);
        check({tag, "_data"}, int'(dout[s]), 0);
        check({tag, "_data_valid"}, int'(dvalid[s]), 0);
        check({tag, "_busy"}, int'(busy[s]), 0);
        check({tag, "_done"}, int'(done[s]), 0);
        check({tag, "_err"}, int'(err[s]), 0);
    endtask

    initial begin
        bitq_t       pay;
        logic [15:0] crc;
        int          d0;

        // Reset held with active-looking inputs: everything must stay cleared.
        rst = 1'b1; sof = 2'b11; valid = 2'b11; din = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero(0, "reset16");
        check_all_zero(1, "reset72");
        sof = '0; valid = '0; din = '0;
        rst = 1'b0;

        // Known good and known bad frame on the 16-bit instance.
        send_frame(0, bits_of(72'h0001, 16), 16'h1021, 0, 32, 1'b0);
        idle(0, 3);
        send_frame(0, bits_of(72'h0001, 16), 16'h1020, 0, 32, 1'b0);
        idle(0, 3);

        // "123456789" with gappy valid on the 72-bit instance.
        d0 = g_mon[1].n_dv;
        send_frame(1, bits_of(72'h313233343536373839, 72), 16'h31C3, 30, 88, 1'b0);
        idle(1, 3);
        check("dv_count72", g_mon[1].n_dv - d0, 72);

        // Back-to-back good frames; busy must stay high throughout.
        d0 = g_mon[0].n_done;
        send_frame(0, bits_of(72'h0001, 16), 16'h1021, 0, 32, 1'b1);
        send_frame(0, bits_of(72'h0000, 16), 16'h0000, 0, 32, 1'b1);
        idle(0, 3);
        check("b2b_done_cnt", g_mon[0].n_done - d0, 2);

        // Restart at payload bit 9, then a full good frame.
        d0 = g_mon[0].n_done;
        pay = rand_bits(16);
        send_frame(0, pay, 16'($urandom), 0, 9, 1'b0);
        pay = rand_bits(16);
        send_frame(0, pay, crc_ref(pay), 10, 32, 1'b0);
        idle(0, 3);
        check("restart_done_cnt", g_mon[0].n_done - d0, 1);

        // Asynchronous reset while in CHECK, mid-cycle.
        d0 = g_mon[0].n_done;
        pay = rand_bits(16);
        send_frame(0, pay, crc_ref(pay), 0, 21, 1'b0);
        @(posedge clk);
        #2;
        sof[0] = 1'b1; valid[0] = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero(0, "midreset");
        @(negedge clk);
        sof[0] = 1'b0; valid[0] = 1'b0;
        rst = 1'b0;
        idle(0, 3);
        check("midreset_done_cnt", g_mon[0].n_done - d0, 0);
        pay = rand_bits(16);
        send_frame(0, pay, crc_ref(pay), 0, 32, 1'b0);
        idle(0, 3);

        // Random frames on both instances, about half with a corrupted CRC bit.
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 2; s++) begin
                pay = rand_bits((s == 0) ? 16 : 72);
                crc = crc_ref(pay);
                if ($urandom_range(1) == 1) crc = crc ^ (16'h0001 << $urandom_range(15));
                send_frame(s, pay, crc, 20, pay.size() + W, 1'b0);
                idle(s, 2);
            end
        end

        // Valid toggling with no start: nothing may happen.
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            valid[0] = ~valid[0];
            sof[0]   = 1'b0;
            din[0]   = 1'($urandom);
            @(negedge clk);
            check("idle_busy", int'(busy[0]), 0);
            check("idle_data_valid", int'(dvalid[0]), 0);
            check("idle_done", int'(done[0]), 0);
        end
        idle(0, 3);
        idle(1, 3);

        check("qd0_empty", g_mon[0].qd.size(), 0);
        check("qe0_empty", g_mon[0].qe.size(), 0);
        check("qd1_empty", g_mon[1].qd.size(), 0);
        check("qe1_empty", g_mon[1].qe.size(), 0);
        check("done_cnt16", g_mon[0].n_done, exp_done_cnt[0]);
        check("done_cnt72", g_mon[1].n_done, exp_done_cnt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
